// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Purpose  : Shared definitions for the two-requester RAM arbiter: sequencer
//            state encoding, requester count, legal read-latency range and a
//            small index-to-one-hot helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

  localparam int N_REQ = 2;

  // Legal range of the RAM read latency (rd strobe to valid data_out).
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Wide enough to count 0 .. RD_LAT_MAX-1 cycles of read wait.
  localparam int LAT_CNT_W = $clog2(RD_LAT_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_t;

  // Requester index to its one-hot bit in gnt / rvalid.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way winner select. Round-robin by default: with both
//            requests high the requester that did not win last time wins.
//            Build macro ARB_FIXED_PRIO_EN selects fixed priority instead
//            (requester 0 always wins a tie) and removes the pointer flop.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset (pointer back to 1)
//            req    - request vector, bit i = requester i
//            take   - a grant is being taken this cycle, update the pointer
//            winner - index of the winning requester (valid when |req)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             take,
  output logic             winner
);

`ifdef ARB_FIXED_PRIO_EN

  // Requester 0 wins whenever it asks; requester 1 only when alone.
  assign winner = ~req[0];

  // Clock, reset and take have no job without the pointer flop.
  logic w_unused;
  assign w_unused = &{clk, rst_n, take, req[1]};

`else

  logic r_last;

  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~r_last;
      default: winner = 1'b0;
    endcase
  end

  // Reset value 1 so that requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (take) begin
      r_last <= winner;
    end
  end

`endif

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Arbiter and sequencer in front of a shared single-port RAM.
//            Grants one access at a time, drives the RAM strobe for exactly
//            one cycle and returns read data with a one-cycle valid pulse.
//            Build macro ARB_FIXED_PRIO_EN (in rr_arb2) switches the tie
//            break from round-robin to fixed priority for requester 0.
// Ports    : clk, rst_n           - clock / async active-low reset
//            req, we, addr, wdata - per-requester request, direction,
//                                   address and write data
//            gnt                  - one-cycle pulse, request committed
//            rvalid, rdata        - one-cycle read-data pulse and data
//            busy                 - sequencer not idle
//            ram_wr, ram_rd, ram_add, ram_data_in, ram_data_out
//                                 - RAM side
// Params   : ADDR_W, DATA_W, RD_LAT (legal 1..4)
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      we,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic                  ram_wr,
  output logic                  ram_rd,
  output logic [ADDR_W-1:0]     ram_add,
  output logic [DATA_W-1:0]     ram_data_in,
  input  logic [DATA_W-1:0]     ram_data_out
);

  // Count value on the last read-wait cycle.
  localparam logic [LAT_CNT_W-1:0] c_last_cnt = LAT_CNT_W'(RD_LAT - 1);

  arb_state_t              r_state;
  arb_state_t              w_next_state;

  logic                    w_winner;
  logic                    w_take;

  logic                    r_sel;
  logic                    r_we;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_wdata;
  logic [LAT_CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]       r_rdata;
  logic [N_REQ-1:0]        r_rvalid;

  logic [N_REQ-1:0]        w_gnt;
  logic                    w_ram_wr;
  logic                    w_ram_rd;
  logic                    w_last_wait;

  // Requests are only looked at while idle; anything arriving during an
  // access waits for the next idle cycle.
  assign w_take      = (r_state == IDLE) && (|req);
  assign w_last_wait = (r_state == RD_WAIT) && (r_cnt == c_last_cnt);

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .take   (w_take),
    .winner (w_winner)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and strobes. Strobes and gnt are decoded from the state so a
  // reset drops them at once.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_gnt        = '0;
    w_ram_wr     = 1'b0;
    w_ram_rd     = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        w_gnt = idx_to_onehot(r_sel);
        if (r_we) begin
          w_ram_wr     = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_ram_rd     = 1'b1;
          w_next_state = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (r_cnt == c_last_cnt) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch, read-latency counter and read return
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= '0;

      if (w_take) begin
        r_sel   <= w_winner;
        r_we    <= w_winner ? we[1] : we[0];
        r_addr  <= w_winner ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
        r_wdata <= w_winner ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
      end

      if (r_state == ACCESS) begin
        r_cnt <= '0;
      end else if (r_state == RD_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // RAM data is valid on the last wait cycle; capture it and flag the
      // owner for one cycle.
      if (w_last_wait) begin
        r_rdata  <= ram_data_out;
        r_rvalid <= idx_to_onehot(r_sel);
      end
    end
  end

  assign gnt         = w_gnt;
  assign rvalid      = r_rvalid;
  assign rdata       = r_rdata;
  assign busy        = (r_state != IDLE);
  assign ram_wr      = w_ram_wr;
  assign ram_rd      = w_ram_rd;
  assign ram_add     = r_addr;
  assign ram_data_in = r_wdata;

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the shared single-port 16x16 RAM (ports clk, wr, rd, add, data_in, data_out).
- Grants one access at a time, drives the RAM strobes for exactly one cycle, and returns read data to the winning requester with a valid pulse.
- Sits between the two bus masters and the RAM instance. The RAM itself is unchanged.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 16, RAM data width.
- RD_LAT, 1, cycles from the RAM rd strobe to valid data_out. Legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  2  access request per requester. Bit i belongs to requester i.
- we  input  2  1 = write, 0 = read. Qualified by req[i].
- addr  input  2*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W].
- wdata  input  2*DATA_W  requester i write data in bits [i*DATA_W +: DATA_W].
- gnt  output  2  one-cycle pulse: the request of requester i has been committed to the RAM.
- rvalid  output  2  one-cycle pulse: rdata holds requester i read result.
- rdata  output  DATA_W  read data shared by both requesters, qualified by rvalid.
- busy  output  1  high whenever state != IDLE.
- ram_wr  output  1  drives RAM wr.
- ram_rd  output  1  drives RAM rd.
- ram_add  output  ADDR_W  drives RAM add.
- ram_data_in  output  DATA_W  drives RAM data_in.
- ram_data_out  input  DATA_W  from RAM data_out.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; gnt, rvalid, ram_wr, ram_rd, busy = 0; rdata, ram_add, ram_data_in = 0.
  - Round-robin pointer last=1, so requester 0 wins first.
- FSM states: IDLE, ACCESS, RD_WAIT.
- IDLE:
  - If any req bit is high at a clock edge, pick the winner w, register we[w], addr[w] and wdata[w], then go to ACCESS.
  - Winner rule: if only one bit is set, that requester wins. If both are set, w = ~last.
  - last <= w on every grant.
- ACCESS (exactly 1 cycle):
  - gnt[w]=1; ram_add = latched address.
  - Write: ram_wr=1, ram_data_in = latched data, next state IDLE.
  - Read: ram_rd=1, next state RD_WAIT, latency counter cleared.
- RD_WAIT: count RD_LAT cycles. On the final cycle, rdata <= ram_data_out, rvalid[w] pulses 1 cycle, then go to IDLE.
- Strobes: ram_wr and ram_rd are never high together and never high outside ACCESS.
- Latency:
  - Write: gnt 1 cycle after req is sampled. Back-to-back writes take 2 cycles each.
  - Read: rvalid at req sample + 1 + RD_LAT + 1 cycles.
- Requester obligations: hold req, we, addr and wdata stable until gnt. Drop req, or present a new request, after gnt.
- Withdrawal: a req withdrawn before the IDLE sample is ignored. Once latched, the access always completes.
- Simultaneous events: a new req arriving during ACCESS or RD_WAIT waits. It is sampled in the next IDLE cycle, so there is one idle-cycle bubble between accesses.
- Reset mid-operation: the access is aborted, strobes drop immediately, no gnt or rvalid is issued for it, and last returns to 1.
- Address wrap: none inside the block. Addresses pass through unchanged.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both req bits are high. The last register is removed.
- Undefined: round-robin as specified in Behaviour.

Decomposition:
- Shared package ram_arb_pkg holds:
  - state enum (IDLE, ACCESS, RD_WAIT);
  - localparam N_REQ=2;
  - RD_LAT legal-range constants.
- One natural sub-module: rr_arb2, the combinational winner select plus the last-pointer flop, with the fixed-priority macro applied there.
- Everything else stays in ram_arbiter.

Test Plan:
- Single write: req=01, we=01, addr0=4'h4, wdata0=16'h00A5 -> gnt=01 one cycle later; ram_wr=1 with ram_add=4, ram_data_in=00A5 for exactly 1 cycle.
- Single read: after that write, req=10, we=00, addr1=4'h4 -> ram_rd pulse, then after RD_LAT=1 rvalid=10 with rdata=16'h00A5.
- Contention: both req high and held after reset -> grant order 0,1,0,1 with round-robin. With ARB_FIXED_PRIO_EN defined -> 0,0,0 while req0 stays high.
- Back-to-back: requester 0 issues writes to 4'hF then 4'h0 -> each ram_wr strobe is 1 cycle, strobes 2 cycles apart, address 4'hF then 4'h0 with no wrap artifacts.
- Reset mid-read: rst_n=0 during RD_WAIT -> rvalid never pulses, outputs 0 immediately; after release, a req from requester 0 is granted first.
- RD_LAT=3 build: a read returns rvalid exactly 5 cycles after the req sample, and rdata matches the stored word.
